multi_spi_adc_frontend: RTL and testbench

- Parametrised successor to the dual MCP3201 front-end. Drives N serial ADCs (MCP3201-class, shared SSN/SCLK, one MISO per channel) from a single frame sequencer.
- Optionally averages 2^AVG_LOG2 conversions per channel.
- Presents all channels as one packed word with a valid/ready handshake and overrun detection.
- Sits between the PMOD pins and the DSP/stream path.

---
 rtl/multi_spi_adc_pkg.sv | 30 +++
 rtl/adc_chan_accum.sv | 56 +++++
 rtl/multi_spi_adc_frontend.sv | 194 +++++++++++++++++++
 tb/tb_multi_spi_adc_frontend.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_spi_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_spi_adc_pkg
// Description : Shared types and frame-timing helpers for the multi-channel
//               serial ADC front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_spi_adc_pkg;

    localparam int MAX_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_e;

    function automatic int calc_frame_clks(input int lead_clks, input int adc_bits,
                                           input int guard_clks);
        return lead_clks + adc_bits + guard_clks;
    endfunction

    // Half SCLK period in system clocks, floored so the frame never runs slow.
    function automatic int calc_half_div(input int clock_freq, input int sample_rate,
                                         input int frame_clks);
        return clock_freq / (2 * sample_rate * frame_clks);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_chan_accum.sv
`default_nettype none
// ============================================================================
// Module      : adc_chan_accum
// Description : Per-channel MISO shift register, frame accumulator and
//               power-of-two averaging divider.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_chan_accum
    import multi_spi_adc_pkg::*;
#(
    parameter int ADC_BITS = 12,
    parameter int AVG_LOG2 = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sample_en_i,
    input  logic                miso_i,
    input  logic                frame_done_i,
    input  logic                avg_last_i,
    output logic [ADC_BITS-1:0] result_o
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;

    logic [ADC_BITS-1:0] shreg_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ADC_BITS-1:0] result_q;
    logic [ACC_W-1:0]    sum_w;

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    assign sum_w = acc_q + ACC_W'(shreg_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (sample_en_i) begin
                shreg_q <= {shreg_q[ADC_BITS-2:0], miso_i};
            end
            if (frame_done_i) begin
                if (avg_last_i) begin
                    acc_q    <= '0;
                    result_q <= sum_w[ACC_W-1:AVG_LOG2];
                end else begin
                    acc_q <= sum_w;
                end
            end
        end
    end

    assign result_o = result_q;

endmodule
`default_nettype wire

// File: rtl/multi_spi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module      : multi_spi_adc_frontend
// Description : Frame sequencer for N MCP3201-class ADCs sharing SSN/SCLK,
//               with optional averaging and a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_spi_adc_frontend
    import multi_spi_adc_pkg::*;
#(
    parameter int CLOCK_FREQ  = 25000000,
    parameter int SAMPLE_RATE = 50000,
    parameter int CHANNELS    = 2,
    parameter int ADC_BITS    = 12,
    parameter int LEAD_CLKS   = 3,
    parameter int GUARD_CLKS  = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         adc_ssn,
    output logic                         adc_sclk,
    input  logic [CHANNELS-1:0]          adc_miso,
    output logic [CHANNELS*ADC_BITS-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun,
    input  logic                         clear_overrun
);

    localparam int FRAME_CLKS = calc_frame_clks(LEAD_CLKS, ADC_BITS, GUARD_CLKS);
    localparam int HALF_DIV   = calc_half_div(CLOCK_FREQ, SAMPLE_RATE, FRAME_CLKS);
    localparam int SHIFT_CLKS = LEAD_CLKS + ADC_BITS;
    localparam int GUARD_LEN  = GUARD_CLKS * 2 * HALF_DIV;
    localparam int AVG_N      = 1 << AVG_LOG2;
    localparam int CNT_W      = 24;
    localparam int BIT_W      = 8;
    localparam int FRM_W      = 5;
    localparam int DATA_W     = CHANNELS * ADC_BITS;

    generate
        if (HALF_DIV < 1 || CHANNELS < 1 || CHANNELS > MAX_CHANNELS ||
            GUARD_CLKS < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_param_check
            $error("multi_spi_adc_frontend: invalid parameters (HALF_DIV=%0d)", HALF_DIV);
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   guard_q, guard_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               result_new_q;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
    logic               sample_en;
    logic               frame_done;
    logic               avg_last;
    logic [DATA_W-1:0]  results;

    assign avg_last = (frame_cnt_q == FRM_W'(AVG_N - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            guard_q      <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            frame_cnt_q  <= '0;
            result_new_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            guard_q      <= guard_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            frame_cnt_q  <= frame_cnt_d;
            result_new_q <= frame_done & avg_last;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        guard_d     = guard_q;
        bit_d       = bit_q;
        sclk_d      = sclk_q;
        frame_cnt_d = frame_cnt_q;
        sample_en   = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                div_d   = '0;
                guard_d = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                if (enable) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == CNT_W'(HALF_DIV - 1)) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising SCLK edge: capture only the data-bit periods.
                        sample_en = (bit_q >= BIT_W'(LEAD_CLKS)) && (bit_q < BIT_W'(SHIFT_CLKS));
                    end else if (bit_q == BIT_W'(SHIFT_CLKS - 1)) begin
                        bit_d      = '0;
                        guard_d    = '0;
                        frame_done = 1'b1;
                        state_d    = GUARD;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            GUARD: begin
                sclk_d = 1'b0;
                if (guard_q == CNT_W'(GUARD_LEN - 1)) begin
                    guard_d = '0;
                    div_d   = '0;
                    state_d = enable ? SHIFT : IDLE;
                end else begin
                    guard_d = guard_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (frame_done) begin
            frame_cnt_d = avg_last ? '0 : frame_cnt_q + FRM_W'(1);
        end
    end

    // A result arriving while the previous one is still held is dropped;
    // the drop takes priority over a simultaneous clear.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (result_new_q) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = results;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
            adc_chan_accum #(
                .ADC_BITS (ADC_BITS),
                .AVG_LOG2 (AVG_LOG2)
            ) u_accum (
                .clk_i        (clock),
                .rst_i        (reset),
                .sample_en_i  (sample_en),
                .miso_i       (adc_miso[ch]),
                .frame_done_i (frame_done),
                .avg_last_i   (avg_last),
                .result_o     (results[ch*ADC_BITS +: ADC_BITS])
            );
        end
    endgenerate

    assign adc_ssn   = (state_q != SHIFT);
    assign adc_sclk  = sclk_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_spi_adc_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_spi_adc_frontend
// Description : Self-checking bench with behavioural ADC models for an
//               unaveraged and a 4-frame-averaging front-end instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_spi_adc_frontend;

    localparam int FRAME = 68;

    typedef struct packed {
        logic [11:0] ch1;
        logic [11:0] ch0;
    } pair_t;

    typedef struct {
        logic [11:0] ch0;
        logic [11:0] ch1;
        logic [23:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
    logic        ssn_a, sclk_a, valid_a, ovr_a;
    logic [1:0]  miso_a;
    logic [23:0] data_a;
    logic        en_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
    logic        ssn_b, sclk_b, valid_b, ovr_b;
    logic [1:0]  miso_b;
    logic [23:0] data_b;

    multi_spi_adc_frontend #(
        .CLOCK_FREQ(3400000), .SAMPLE_RATE(50000), .CHANNELS(2), .ADC_BITS(12),
        .LEAD_CLKS(3), .GUARD_CLKS(2), .AVG_LOG2(0)
    ) dut_a (
        .clock(clk), .reset(rst), .enable(en_a), .adc_ssn(ssn_a), .adc_sclk(sclk_a),
        .adc_miso(miso_a), .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
        .overrun(ovr_a), .clear_overrun(clr_a)
    );

    multi_spi_adc_frontend #(
        .CLOCK_FREQ(3400000), .SAMPLE_RATE(50000), .CHANNELS(2), .ADC_BITS(12),
        .LEAD_CLKS(3), .GUARD_CLKS(2), .AVG_LOG2(2)
    ) dut_b (
        .clock(clk), .reset(rst), .enable(en_b), .adc_ssn(ssn_b), .adc_sclk(sclk_b),
        .adc_miso(miso_b), .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
        .overrun(ovr_b), .clear_overrun(clr_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: lead periods drive 1, then the word MSB first.
    function automatic logic adc_bit(input logic [11:0] w, input int r);
        if (r >= 3 && r < 15) return w[11 - (r - 3)];
        return 1'b1;
    endfunction

    pair_t wq_a[$], wq_b[$];
    pair_t cur_a = '0, cur_b = '0;
    int    rise_a = 0, rise_b = 0, last_rise_a = 0, frames_b = 0;

    always @(negedge ssn_a or posedge sclk_a) begin
        if (sclk_a) rise_a++;
        else begin
            rise_a = 0;
            cur_a  = (wq_a.size() > 0) ? wq_a.pop_front() : '0;
        end
    end
    always @(negedge ssn_b or posedge sclk_b) begin
        if (sclk_b) rise_b++;
        else begin
            rise_b = 0;
            cur_b  = (wq_b.size() > 0) ? wq_b.pop_front() : '0;
        end
    end
    always @(posedge ssn_a) last_rise_a = rise_a;
    always @(posedge ssn_b) frames_b++;

    assign miso_a = {adc_bit(cur_a.ch1, rise_a), adc_bit(cur_a.ch0, rise_a)};
    assign miso_b = {adc_bit(cur_b.ch1, rise_b), adc_bit(cur_b.ch0, rise_b)};

    int   cyc = 0;
    int   run_a = 0, last_low_a = 0, last_high_a = 0;
    logic ssn_prev_a = 1'b1;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (ssn_a !== ssn_prev_a) begin
            if (ssn_prev_a) last_high_a = run_a;
            else            last_low_a  = run_a;
            run_a = 0;
        end
        run_a++;
        ssn_prev_a = ssn_a;
    end

    task automatic wait_cond(input int sel, input int bound, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            @(negedge clk);
            case (sel)
                0:       ok = valid_a;
                1:       ok = valid_b;
                2:       ok = ovr_a;
                3:       ok = !ssn_a;
                default: ok = !ssn_b;
            endcase
            n++;
        end
    endtask

    initial begin
        vec_t        vecs[5];
        pair_t       p;
        bit          ok;
        logic [23:0] held;
        logic [23:0] exp_q[$];
        int          t_prev = 0;
        int          viol;
        int          s0, s1;

        vecs[0] = '{12'hA5C, 12'h123, 24'h123A5C};
        vecs[1] = '{12'h000, 12'hFFF, 24'hFFF000};
        vecs[2] = '{12'hFFF, 12'h000, 24'h000FFF};
        vecs[3] = '{12'h555, 12'hAAA, 24'hAAA555};
        vecs[4] = '{12'h801, 12'h001, 24'h001801};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ssn", ssn_a, 1);
        chk("reset_sclk", sclk_a, 0);
        chk("reset_data", data_a, 0);
        chk("reset_valid", valid_a, 0);
        chk("reset_overrun", ovr_a, 0);
        chk("reset_ssn_b", ssn_b, 1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back frames with a consumer that is always ready.
        foreach (vecs[i]) wq_a.push_back('{vecs[i].ch1, vecs[i].ch0});
        ready_a = 1'b1;
        en_a    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cond(0, 300, ok);
            chk($sformatf("vec%0d_timeout", i), ok, 1);
            chk($sformatf("vec%0d_data", i), data_a, vecs[i].exp);
            if (i > 0) chk($sformatf("vec%0d_period", i), cyc - t_prev, FRAME);
            t_prev = cyc;
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), valid_a, 0);
        end
        chk("ssn_low_clks", last_low_a, 60);
        chk("ssn_high_clks", last_high_a, 8);
        chk("rises_per_frame", last_rise_a, 15);
        chk("table_overrun", ovr_a, 0);
        en_a = 1'b0;
        repeat (150) @(negedge clk);

        // Random words with random consumer back-pressure shorter than a frame.
        wq_a.delete();
        for (int i = 0; i < 8; i++) begin
            p.ch0 = 12'($urandom);
            p.ch1 = 12'($urandom);
            wq_a.push_back(p);
            exp_q.push_back({p.ch1, p.ch0});
        end
        ready_a = 1'b0;
        en_a    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_cond(0, 300, ok);
            chk($sformatf("rand%0d_timeout", i), ok, 1);
            held = data_a;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            chk($sformatf("rand%0d_hold", i), data_a, held);
            chk($sformatf("rand%0d_valid", i), valid_a, 1);
            chk($sformatf("rand%0d_data", i), data_a, exp_q.pop_front());
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
        end
        chk("rand_overrun", ovr_a, 0);
        en_a    = 1'b0;
        ready_a = 1'b1;
        repeat (200) @(negedge clk);

        // Two results with no consumer: the second is dropped.
        wq_a.delete();
        wq_a.push_back('{12'h222, 12'h111});
        wq_a.push_back('{12'h444, 12'h333});
        wq_a.push_back('{12'h666, 12'h555});
        ready_a = 1'b0;
        en_a    = 1'b1;
        wait_cond(0, 300, ok);
        chk("ovr_first_timeout", ok, 1);
        chk("ovr_first_data", data_a, 24'h222111);
        wait_cond(2, 300, ok);
        chk("ovr_set_timeout", ok, 1);
        en_a = 1'b0;
        chk("ovr_data_kept", data_a, 24'h222111);
        repeat (150) @(negedge clk);
        chk("ovr_data_kept_late", data_a, 24'h222111);
        chk("ovr_sticky", ovr_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovr_cleared", ovr_a, 0);
        chk("ovr_valid_held", valid_a, 1);
        ready_a = 1'b1;
        @(negedge clk);
        chk("ovr_accepted", valid_a, 0);

        // Enable dropped ten clocks into SHIFT.
        wq_a.delete();
        wq_a.push_back('{12'h9AB, 12'h3C4});
        en_a = 1'b1;
        wait_cond(3, 300, ok);
        chk("endrop_start_timeout", ok, 1);
        repeat (9) @(negedge clk);
        en_a = 1'b0;
        wait_cond(0, 300, ok);
        chk("endrop_timeout", ok, 1);
        chk("endrop_data", data_a, 24'h9AB3C4);
        repeat (10) @(negedge clk);
        chk("endrop_low_clks", last_low_a, 60);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (ssn_a !== 1'b1 || sclk_a !== 1'b0) viol++;
        end
        chk("endrop_idle_stable", viol, 0);

        // Asynchronous reset in the middle of SHIFT.
        wq_a.delete();
        wq_a.push_back('{12'hBAD, 12'hBAD});
        wq_a.push_back('{12'h7E1, 12'h0F0});
        en_a = 1'b1;
        wait_cond(3, 300, ok);
        chk("arst_start_timeout", ok, 1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ssn", ssn_a, 1);
        chk("arst_sclk", sclk_a, 0);
        chk("arst_valid", valid_a, 0);
        chk("arst_data", data_a, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cond(0, 300, ok);
        chk("arst_new_timeout", ok, 1);
        chk("arst_new_data", data_a, 24'h7E10F0);
        en_a = 1'b0;
        repeat (150) @(negedge clk);

        // Averaging instance: one known group, then two random groups.
        wq_b.delete();
        exp_q.delete();
        wq_b.push_back('{12'hFFF, 12'h100});
        wq_b.push_back('{12'hFFF, 12'h101});
        wq_b.push_back('{12'hFFE, 12'h102});
        wq_b.push_back('{12'hFFD, 12'h104});
        exp_q.push_back(24'hFFE101);
        for (int g = 0; g < 2; g++) begin
            s0 = 0;
            s1 = 0;
            for (int f = 0; f < 4; f++) begin
                p.ch0 = 12'($urandom);
                p.ch1 = 12'($urandom);
                s0 += int'(p.ch0);
                s1 += int'(p.ch1);
                wq_b.push_back(p);
            end
            exp_q.push_back({12'(s1 / 4), 12'(s0 / 4)});
        end
        frames_b = 0;
        ready_b  = 1'b1;
        en_b     = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_cond(1, 400, ok);
            chk($sformatf("avg%0d_timeout", g), ok, 1);
            chk($sformatf("avg%0d_frames", g), frames_b, 4 * (g + 1));
            chk($sformatf("avg%0d_data", g), data_b, exp_q.pop_front());
            @(negedge clk);
        end
        chk("avg_overrun", ovr_b, 0);
        en_b = 1'b0;
        repeat (200) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
